// File: rtl/pcie_rd_req_splitter_if.sv
// Bundle of the three handshake channels around the read-request splitter.
//  s_desc_* : DMA read descriptors in (valid/ready)
//  m_tcq_*  : chunk requests out to the PCIe requester, plus chunk completions back
//  m_done_* : in-order descriptor completion reports out
// modport slave  = splitter view, modport master = descriptor source / requester / done sink view.
interface pcie_rd_req_splitter_if #(
  parameter int LOCAL_ADDR_WIDTH  = 17,
  parameter int REMOTE_ADDR_WIDTH = 32,
  parameter int REQUEST_LEN_BITS  = 9,
  parameter int DESC_LEN_BITS     = 20,
  parameter int MEM_TAG           = 4,
  parameter int DATA_BITS         = 4,
  parameter int ID_WIDTH          = 8
);
  logic                                    s_desc_valid;
  logic                                    s_desc_ready;
  logic [LOCAL_ADDR_WIDTH-DATA_BITS-1:0]   s_desc_laddr;
  logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0]  s_desc_raddr;
  logic [DESC_LEN_BITS-DATA_BITS-1:0]      s_desc_len;
  logic [ID_WIDTH-1:0]                     s_desc_id;

  logic                                    m_tcq_valid;
  logic                                    m_tcq_ready;
  logic [LOCAL_ADDR_WIDTH-DATA_BITS-1:0]   m_tcq_laddr;
  logic [REMOTE_ADDR_WIDTH-DATA_BITS-1:0]  m_tcq_raddr;
  logic [REQUEST_LEN_BITS-DATA_BITS-1:0]   m_tcq_length;
  logic [MEM_TAG-1:0]                      m_tcq_tag;
  logic                                    m_tcq_cvalid;
  logic                                    m_tcq_cready;
  logic [MEM_TAG-1:0]                      m_tcq_ctag;

  logic                                    m_done_valid;
  logic                                    m_done_ready;
  logic [ID_WIDTH-1:0]                     m_done_id;

  modport slave (
    input  s_desc_valid, s_desc_laddr, s_desc_raddr, s_desc_len, s_desc_id,
    output s_desc_ready,
    output m_tcq_valid, m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag, m_tcq_cready,
    input  m_tcq_ready, m_tcq_cvalid, m_tcq_ctag,
    output m_done_valid, m_done_id,
    input  m_done_ready
  );

  modport master (
    output s_desc_valid, s_desc_laddr, s_desc_raddr, s_desc_len, s_desc_id,
    input  s_desc_ready,
    input  m_tcq_valid, m_tcq_laddr, m_tcq_raddr, m_tcq_length, m_tcq_tag, m_tcq_cready,
    output m_tcq_ready, m_tcq_cvalid, m_tcq_ctag,
    input  m_done_valid, m_done_id,
    output m_done_ready
  );
endinterface

// File: rtl/pcie_rd_req_splitter.sv
// Splits DMA read descriptors into MemRd chunks for the PCIe read requester.
// Chunk size is the minimum of the words left, the MRRS, the requester length cap and the
// distance to the next 4KB remote boundary. Each chunk takes the lowest free tag; tags are
// returned by completions, and each descriptor (held in a slot ring) is reported done in order.
// Ports:
//  clk, rst               clock, synchronous active-high reset
//  cfg_max_read_req_i     MRRS code 0=128B..5=4096B (6,7 behave as 5)
//  bus                    splitter side of pcie_rd_req_splitter_if (desc in, chunks out, cpl in, done out)
//  stat_busy_tags_o       number of outstanding tags
//  stat_spurious_o        completions seen on a non-busy tag (wraps)
module pcie_rd_req_splitter #(
  parameter int LOCAL_ADDR_WIDTH  = 17,
  parameter int REMOTE_ADDR_WIDTH = 32,
  parameter int REQUEST_LEN_BITS  = 9,
  parameter int DESC_LEN_BITS     = 20,
  parameter int MEM_TAG           = 4,
  parameter int DATA_BITS         = 4,
  parameter int SLOT_BITS         = 2,
  parameter int ID_WIDTH          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          cfg_max_read_req_i,
  pcie_rd_req_splitter_if.slave bus,
  output logic [MEM_TAG:0]    stat_busy_tags_o,
  output logic [15:0]         stat_spurious_o
);
  localparam int LW    = LOCAL_ADDR_WIDTH - DATA_BITS;
  localparam int RW    = REMOTE_ADDR_WIDTH - DATA_BITS;
  localparam int NW    = DESC_LEN_BITS - DATA_BITS + 1;  // words-left counter, holds len+1
  localparam int CW    = REQUEST_LEN_BITS - DATA_BITS;
  localparam int BW    = 12 - DATA_BITS;                 // word-offset bits inside a 4KB page
  localparam int NTAG  = 1 << MEM_TAG;
  localparam int NSLOT = 1 << SLOT_BITS;

  localparam logic [NW-1:0]      LIM_CAP = NW'(2**CW);
  localparam logic [NW-1:0]      PAGE_W  = NW'(2**BW);
  localparam logic [MEM_TAG:0]   CNT_ONE = (MEM_TAG+1)'(1);
  localparam logic [SLOT_BITS-1:0] PTR_ONE = SLOT_BITS'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  logic [0:0]                        fsm_q, fsm_d;
  logic [LW-1:0]                     laddr_q, laddr_d;
  logic [RW-1:0]                     raddr_q, raddr_d;
  logic [NW-1:0]                     left_q, left_d;

  logic                              tcq_valid_q, tcq_valid_d;
  logic [LW-1:0]                     tcq_laddr_q, tcq_laddr_d;
  logic [RW-1:0]                     tcq_raddr_q, tcq_raddr_d;
  logic [CW-1:0]                     tcq_len_q, tcq_len_d;
  logic [MEM_TAG-1:0]                tcq_tag_q, tcq_tag_d;

  logic [NTAG-1:0]                   busy_q, busy_d;
  logic [NTAG-1:0][SLOT_BITS-1:0]    tag_slot_q, tag_slot_d;
  logic [MEM_TAG:0]                  busy_cnt_q, busy_cnt_d;

  logic [NSLOT-1:0]                  slot_used_q, slot_used_d;
  logic [NSLOT-1:0]                  slot_issued_q, slot_issued_d;
  logic [NSLOT-1:0][MEM_TAG:0]       slot_cnt_q, slot_cnt_d;
  logic [NSLOT-1:0][ID_WIDTH-1:0]    slot_id_q, slot_id_d;
  logic [SLOT_BITS-1:0]              head_q, head_d, tail_q, tail_d;

  logic                              done_valid_q, done_valid_d;
  logic [15:0]                       spur_q, spur_d;

  logic                              desc_ready, desc_fire, done_fire, issue, cpl_ok;
  logic                              tag_avail;
  logic [MEM_TAG-1:0]                free_tag;
  logic [SLOT_BITS-1:0]              cpl_slot;
  logic [2:0]                        mrrs_code;
  logic [NW-1:0]                     lim_mrrs, lim_bnd, n;

  always_comb begin
    // lowest-index free tag, from the registered bitmap so a freed tag waits one cycle
    tag_avail = 1'b0;
    free_tag  = '0;
    for (int t = NTAG-1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        tag_avail = 1'b1;
        free_tag  = MEM_TAG'(t);
      end
    end

    mrrs_code = (cfg_max_read_req_i > 3'd5) ? 3'd5 : cfg_max_read_req_i;
    lim_mrrs  = NW'((32'd128 << mrrs_code) >> DATA_BITS);
    lim_bnd   = PAGE_W - NW'(raddr_q[BW-1:0]);
    n = left_q;
    if (lim_mrrs < n) n = lim_mrrs;
    if (LIM_CAP  < n) n = LIM_CAP;
    if (lim_bnd  < n) n = lim_bnd;

    desc_ready = (fsm_q == ST_IDLE) && !slot_used_q[tail_q];
    desc_fire  = bus.s_desc_valid && desc_ready;
    done_fire  = done_valid_q && bus.m_done_ready;
    issue      = (fsm_q == ST_SPLIT) && tag_avail && (!tcq_valid_q || bus.m_tcq_ready);
    cpl_ok     = bus.m_tcq_cvalid && busy_q[bus.m_tcq_ctag];
    cpl_slot   = tag_slot_q[bus.m_tcq_ctag];

    fsm_d         = fsm_q;
    laddr_d       = laddr_q;
    raddr_d       = raddr_q;
    left_d        = left_q;
    tcq_valid_d   = tcq_valid_q;
    tcq_laddr_d   = tcq_laddr_q;
    tcq_raddr_d   = tcq_raddr_q;
    tcq_len_d     = tcq_len_q;
    tcq_tag_d     = tcq_tag_q;
    busy_d        = busy_q;
    tag_slot_d    = tag_slot_q;
    busy_cnt_d    = busy_cnt_q;
    slot_used_d   = slot_used_q;
    slot_issued_d = slot_issued_q;
    slot_cnt_d    = slot_cnt_q;
    slot_id_d     = slot_id_q;
    head_d        = head_q;
    tail_d        = tail_q;
    spur_d        = spur_q;

    if (desc_fire) begin
      fsm_d                 = ST_SPLIT;
      laddr_d               = bus.s_desc_laddr;
      raddr_d               = bus.s_desc_raddr;
      left_d                = {1'b0, bus.s_desc_len} + NW'(1);
      slot_used_d[tail_q]   = 1'b1;
      slot_issued_d[tail_q] = 1'b0;
      slot_id_d[tail_q]     = bus.s_desc_id;
    end

    if (issue) begin
      tcq_valid_d          = 1'b1;
      tcq_laddr_d          = laddr_q;
      tcq_raddr_d          = raddr_q;
      tcq_len_d            = CW'(n - NW'(1));
      tcq_tag_d            = free_tag;
      busy_d[free_tag]     = 1'b1;
      tag_slot_d[free_tag] = tail_q;
      laddr_d              = laddr_q + LW'(n);
      raddr_d              = raddr_q + RW'(n);
      left_d               = left_q - n;
      if (left_q == n) begin
        slot_issued_d[tail_q] = 1'b1;
        tail_d                = tail_q + PTR_ONE;
        fsm_d                 = ST_IDLE;
      end
    end else if (bus.m_tcq_ready) begin
      tcq_valid_d = 1'b0;
    end

    // the completing tag is busy and the issued tag was free, so they never collide
    if (cpl_ok)                 busy_d[bus.m_tcq_ctag] = 1'b0;
    else if (bus.m_tcq_cvalid)  spur_d = spur_q + 16'd1;

    for (int s = 0; s < NSLOT; s++) begin
      if (issue  && tail_q   == SLOT_BITS'(s)) slot_cnt_d[s] = slot_cnt_d[s] + CNT_ONE;
      if (cpl_ok && cpl_slot == SLOT_BITS'(s)) slot_cnt_d[s] = slot_cnt_d[s] - CNT_ONE;
    end
    if (issue)  busy_cnt_d = busy_cnt_d + CNT_ONE;
    if (cpl_ok) busy_cnt_d = busy_cnt_d - CNT_ONE;

    if (done_fire) begin
      slot_used_d[head_q]   = 1'b0;
      slot_issued_d[head_q] = 1'b0;
      head_d                = head_q + PTR_ONE;
    end

    // evaluated on next-state values so a just-retired slot never re-reports
    done_valid_d = slot_issued_d[head_d] && (slot_cnt_d[head_d] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= ST_IDLE;
      laddr_q       <= '0;
      raddr_q       <= '0;
      left_q        <= '0;
      tcq_valid_q   <= 1'b0;
      tcq_laddr_q   <= '0;
      tcq_raddr_q   <= '0;
      tcq_len_q     <= '0;
      tcq_tag_q     <= '0;
      busy_q        <= '0;
      tag_slot_q    <= '0;
      busy_cnt_q    <= '0;
      slot_used_q   <= '0;
      slot_issued_q <= '0;
      slot_cnt_q    <= '0;
      slot_id_q     <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      done_valid_q  <= 1'b0;
      spur_q        <= '0;
    end else begin
      fsm_q         <= fsm_d;
      laddr_q       <= laddr_d;
      raddr_q       <= raddr_d;
      left_q        <= left_d;
      tcq_valid_q   <= tcq_valid_d;
      tcq_laddr_q   <= tcq_laddr_d;
      tcq_raddr_q   <= tcq_raddr_d;
      tcq_len_q     <= tcq_len_d;
      tcq_tag_q     <= tcq_tag_d;
      busy_q        <= busy_d;
      tag_slot_q    <= tag_slot_d;
      busy_cnt_q    <= busy_cnt_d;
      slot_used_q   <= slot_used_d;
      slot_issued_q <= slot_issued_d;
      slot_cnt_q    <= slot_cnt_d;
      slot_id_q     <= slot_id_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      done_valid_q  <= done_valid_d;
      spur_q        <= spur_d;
    end
  end

  assign bus.s_desc_ready  = desc_ready;
  assign bus.m_tcq_valid   = tcq_valid_q;
  assign bus.m_tcq_laddr   = tcq_laddr_q;
  assign bus.m_tcq_raddr   = tcq_raddr_q;
  assign bus.m_tcq_length  = tcq_len_q;
  assign bus.m_tcq_tag     = tcq_tag_q;
  assign bus.m_tcq_cready  = 1'b1;
  assign bus.m_done_valid  = done_valid_q;
  assign bus.m_done_id     = slot_id_q[head_q];
  assign stat_busy_tags_o  = busy_cnt_q;
  assign stat_spurious_o   = spur_q;
endmodule
